sha256_iter_core: RTL and testbench

SHA256_ITER_CORE -- requirements
Module: sha256_iter_core

---
 rtl/sha256_iter_core.sv | 177 +++++++++++++++++
 tb/tb_sha256_iter_core.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_iter_core.sv
// Iterative SHA-256 compression core: one 512-bit block per handshake, RPC rounds per clock.
// Chaining value comes from the standard IV, an external H_in, or the internal chain register.
module sha256_iter_core #(
    parameter int unsigned RPC = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   mode,
    input  logic [511:0] M_in,
    input  logic [255:0] H_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] H_out,
    output logic         busy
);

    localparam int unsigned CNT_W    = 7;
    localparam int unsigned LAST_CNT = 64;

    if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8)) begin : g_bad_rpc
        $fatal(1, "sha256_iter_core: RPC must be 1, 2, 4 or 8");
    end

    // Word 7 holds H0/a (bus MSB), word 0 holds H7/h; message word 15 is the current W_t.
    typedef logic [7:0][31:0]  hvec_t;
    typedef logic [15:0][31:0] wvec_t;
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    localparam logic [255:0] IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    state_t             state_q, state_d;
    logic               accept, do_round, finish;
    logic [CNT_W-1:0]   rnd_cnt_q;
    wvec_t              w_q, rw_c;
    hvec_t              v_q, rv_c;
    hvec_t              base_q, base_sel_c, chain_q, sum_c;
    logic [31:0]        t1, t2, nw;

    // Next-state and handshake strobes
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        do_round = 1'b0;
        finish   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept  = 1'b1;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                if (rnd_cnt_q == CNT_W'(LAST_CNT)) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end else begin
                    do_round = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Chaining-value source; reserved mode 11 falls back to the IV
    always_comb begin
        case (mode)
            2'b01:   base_sel_c = H_in;
            2'b10:   base_sel_c = chain_q;
            default: base_sel_c = IV;
        endcase
    end

    // RPC unrolled rounds with the rolling 16-word schedule
    always_comb begin
        rv_c = v_q;
        rw_c = w_q;
        t1   = '0;
        t2   = '0;
        nw   = '0;
        for (int unsigned j = 0; j < RPC; j++) begin
            t1 = rv_c[0] + bsig1(rv_c[3]) + ((rv_c[3] & rv_c[2]) ^ (~rv_c[3] & rv_c[1]))
               + K_TAB[6'(rnd_cnt_q) + 6'(j)] + rw_c[15];
            t2 = bsig0(rv_c[7])
               + ((rv_c[7] & rv_c[6]) ^ (rv_c[7] & rv_c[5]) ^ (rv_c[6] & rv_c[5]));
            nw = ssig1(rw_c[1]) + rw_c[6] + ssig0(rw_c[14]) + rw_c[15];
            rv_c = {t1 + t2, rv_c[7:5], rv_c[4] + t1, rv_c[3:1]};
            rw_c = {rw_c[14:0], nw};
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            sum_c[i] = base_q[i] + v_q[i];
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            H_out     <= '0;
            rnd_cnt_q <= '0;
            w_q       <= '0;
            v_q       <= '0;
            base_q    <= '0;
            chain_q   <= IV;
        end else begin
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
            busy      <= (state_d != IDLE);
            if (accept) begin
                w_q       <= M_in;
                v_q       <= base_sel_c;
                base_q    <= base_sel_c;
                rnd_cnt_q <= '0;
            end else if (do_round) begin
                w_q       <= rw_c;
                v_q       <= rv_c;
                rnd_cnt_q <= rnd_cnt_q + CNT_W'(RPC);
            end
            if (finish) begin
                H_out   <= sum_c;
                chain_q <= sum_c;
            end
        end
    end

endmodule

// File: tb/tb_sha256_iter_core.sv
// Scoreboard bench for sha256_iter_core: four instances (RPC = 1, 2, 4, 8) share block/mode inputs.
module tb_sha256_iter_core;

    localparam logic [255:0] IV        = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] TWO_MID   = 256'h85e655d6417a17953363376a624cde5c76e09589cac5f811cc4b32c1f20e533a;
    localparam logic [255:0] TWO_DIG   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
    localparam logic [511:0] TWO_B1    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                          32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO_B2    = {480'h0, 32'h000001c0};

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   in_valid, out_ready, in_ready, out_valid, busy;
    logic [1:0]   mode;
    logic [511:0] m_blk;
    logic [255:0] h_in;
    logic [255:0] h_out [4];

    int           n_tests;
    int           n_fail;
    logic [255:0] exp_q [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sha256_iter_core #(.RPC(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .mode      (mode),
            .M_in      (m_blk),
            .H_in      (h_in),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .H_out     (h_out[g]),
            .busy      (busy[g])
        );
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    // Offer one block to instance d, hold in_valid with garbage inputs, and check the digest
    task automatic run_block(input int d, input logic [1:0] m, input logic [511:0] blk,
                             input logic [255:0] hin, input logic [255:0] expd,
                             input int hold, input string name);
        int           lat;
        bit           ok;
        logic [255:0] want;
        lat = 0;
        while (in_ready[d] !== 1'b1 && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        n_tests++;
        if (in_ready[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ready: in_ready=%b required 1", name, in_ready[d]);
        end
        mode        = m;
        m_blk       = blk;
        h_in        = hin;
        in_valid[d] = 1'b1;
        exp_q.push_back(expd);
        @(posedge clk); #1;
        mode  = 2'($urandom());
        m_blk = {16{$urandom()}};
        h_in  = {8{$urandom()}};
        n_tests++;
        if ({busy[d], in_ready[d]} !== 2'b10) begin
            n_fail++;
            $display("FAIL %s_busy: busy,in_ready=%b required 10", name, {busy[d], in_ready[d]});
        end
        lat = 0;
        while (out_valid[d] !== 1'b1 && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        n_tests++;
        if (lat !== 64 / (1 << d) + 1) begin
            n_fail++;
            $display("FAIL %s_latency: %0d edges required %0d", name, lat, 64 / (1 << d) + 1);
        end
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_tests++;
        if (h_out[d] !== want) begin
            n_fail++;
            $display("FAIL %s_digest: got %h required %h", name, h_out[d], want);
        end
        ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (out_valid[d] !== 1'b1 || h_out[d] !== want || in_ready[d] !== 1'b0) ok = 1'b0;
        end
        if (hold > 0) begin
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL %s_stall: ov=%b ir=%b h=%h required ov=1 ir=0 h=%h",
                         name, out_valid[d], in_ready[d], h_out[d], want);
            end
        end
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
        n_tests++;
        if ({out_valid[d], in_ready[d], busy[d]} !== 3'b010) begin
            n_fail++;
            $display("FAIL %s_handshake: ov,ir,busy=%b required 010",
                     name, {out_valid[d], in_ready[d], busy[d]});
        end
        n_tests++;
        if (h_out[d] !== want) begin
            n_fail++;
            $display("FAIL %s_hold: got %h required %h", name, h_out[d], want);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            n_tests++;
            if ({out_valid[d], busy[d], in_ready[d]} !== 3'b000 || h_out[d] !== 256'h0) begin
                n_fail++;
                $display("FAIL reset_state%0d: ov,busy,ir=%b h=%h required 000 and 0",
                         d, {out_valid[d], busy[d], in_ready[d]}, h_out[d]);
            end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (in_ready !== 4'hf) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b required 1111", in_ready);
        end
    endtask

    task automatic test_iv_default();
        run_block(3, 2'b10, ABC_BLK, {8{$urandom()}}, ABC_DIG, 0, "chain_iv_rpc8");
    endtask

    task automatic test_abc_rpc1();
        run_block(0, 2'b00, ABC_BLK, {8{$urandom()}}, ABC_DIG, 0, "abc_rpc1");
    endtask

    task automatic test_empty_rpc4();
        run_block(2, 2'b01, EMPTY_BLK, IV, EMPTY_DIG, 0, "empty_rpc4");
    endtask

    task automatic test_two_block();
        run_block(0, 2'b00, TWO_B1, {8{$urandom()}}, TWO_MID, 0, "two_blk1");
        run_block(0, 2'b10, TWO_B2, {8{$urandom()}}, TWO_DIG, 0, "two_blk2");
    endtask

    task automatic test_stall();
        run_block(0, 2'b00, ABC_BLK, {8{$urandom()}}, ABC_DIG, 20, "stall");
    endtask

    task automatic test_back_to_back();
        run_block(1, 2'b00, ABC_BLK, {8{$urandom()}}, ABC_DIG, 0, "abc_rpc2");
        run_block(3, 2'b00, ABC_BLK, {8{$urandom()}}, ABC_DIG, 0, "abc_rpc8");
        run_block(1, 2'b11, ABC_BLK, {8{$urandom()}}, ABC_DIG, 0, "mode11_rpc2");
        run_block(3, 2'b01, ABC_BLK, IV, ABC_DIG, 0, "hin_rpc8");
    endtask

    task automatic test_abort();
        bit quiet;
        while (in_ready[0] !== 1'b1) begin
            @(posedge clk); #1;
        end
        mode        = 2'b00;
        m_blk       = EMPTY_BLK;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (30) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({out_valid[0], busy[0], in_ready[0]} !== 3'b000 || h_out[0] !== 256'h0) begin
            n_fail++;
            $display("FAIL abort_reset: ov,busy,ir=%b h=%h required 000 and 0",
                     {out_valid[0], busy[0], in_ready[0]}, h_out[0]);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (in_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_release: in_ready=%b required 1", in_ready[0]);
        end
        quiet = 1'b1;
        repeat (80) begin
            @(posedge clk); #1;
            if (out_valid !== 4'h0) quiet = 1'b0;
        end
        n_tests++;
        if (!quiet) begin
            n_fail++;
            $display("FAIL abort_no_output: out_valid=%b required 0000", out_valid);
        end
        run_block(0, 2'b10, ABC_BLK, {8{$urandom()}}, ABC_DIG, 0, "abort_chain_iv");
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = '0;
        mode      = 2'b00;
        m_blk     = '0;
        h_in      = '0;
        test_reset();
        test_iv_default();
        test_abc_rpc1();
        test_empty_rpc4();
        test_two_block();
        test_stall();
        test_back_to_back();
        test_abort();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
